// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard and forwarding controller for the 5-stage
// F/D/E/M/W core. Keeps a shadow copy of the control metadata for E, M
// and W. From it, generates stall, flush and operand-forward selects for
// the datapath pipeline registers. Also stalls the front end while a
// multi-cycle execute op is in progress.
//
// Ports:
//   i_clk, i_rst          clock (rising edge), async active-low reset
//   i_validD..i_multiCycleD  decode-stage instruction metadata
//   i_branchTakenE        branch resolved taken in E
//   o_stallF/D/E          hold PC / F-D register / D-E register
//   o_flushD/E/M          clear F-D / bubble into D-E / bubble into E-M
//   o_fwdAE, o_fwdBE      operand source: 00 regfile, 01 W, 10 M
//   o_busyE               multi-cycle op still counting down in E
module pipe_hazard_ctrl #(
  parameter int NUM_REGS           = 4,
  parameter int ADDRESS_WIDTH      = $clog2(NUM_REGS),
  parameter int MC_LATENCY         = 4,
  parameter int ZERO_REG_HARDWIRED = 0
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_validD,
  input  logic [ADDRESS_WIDTH-1:0] i_rs1D,
  input  logic [ADDRESS_WIDTH-1:0] i_rs2D,
  input  logic                     i_useRs1D,
  input  logic                     i_useRs2D,
  input  logic [ADDRESS_WIDTH-1:0] i_rdD,
  input  logic                     i_regWriteD,
  input  logic                     i_memReadD,
  input  logic                     i_multiCycleD,
  input  logic                     i_branchTakenE,
  output logic                     o_stallF,
  output logic                     o_stallD,
  output logic                     o_stallE,
  output logic                     o_flushD,
  output logic                     o_flushE,
  output logic                     o_flushM,
  output logic [1:0]               o_fwdAE,
  output logic [1:0]               o_fwdBE,
  output logic                     o_busyE
);

  localparam int CW = $clog2(MC_LATENCY);
  localparam logic [CW-1:0] CNT_LOAD = CW'(MC_LATENCY - 1);

  typedef logic [ADDRESS_WIDTH-1:0] ra_t;

  // The multi-cycle flag is consumed on entry (counter load), and memRead
  // only matters in E (load-use), so later stages carry just the writeback
  // fields that forwarding needs.
  typedef struct packed {
    logic v;
    ra_t  rd;
    logic rw;
    logic mr;
    ra_t  rs1;
    ra_t  rs2;
    logic u1;
    logic u2;
  } e_stg_t;

  typedef struct packed {
    logic v;
    ra_t  rd;
    logic rw;
  } wb_stg_t;

  e_stg_t        e_q, e_d;
  wb_stg_t       m_q, m_d, w_q, w_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic busy, lu;

  function automatic logic match(input logic v, input logic rw, input ra_t rd, input ra_t r);
    return v & rw & (rd == r) & ((ZERO_REG_HARDWIRED == 0) || (r != '0));
  endfunction

  assign busy    = (cnt_q != '0);
  assign o_busyE = busy;

  assign lu = e_q.v & e_q.mr & i_validD &
              ((i_useRs1D & match(e_q.v, e_q.rw, e_q.rd, i_rs1D)) |
               (i_useRs2D & match(e_q.v, e_q.rw, e_q.rd, i_rs2D)));

  // Forward selects; M is younger than W so it wins.
  always_comb begin
    o_fwdAE = 2'b00;
    o_fwdBE = 2'b00;
    if (e_q.v && e_q.u1) begin
      if (match(m_q.v, m_q.rw, m_q.rd, e_q.rs1))      o_fwdAE = 2'b10;
      else if (match(w_q.v, w_q.rw, w_q.rd, e_q.rs1)) o_fwdAE = 2'b01;
    end
    if (e_q.v && e_q.u2) begin
      if (match(m_q.v, m_q.rw, m_q.rd, e_q.rs2))      o_fwdBE = 2'b10;
      else if (match(w_q.v, w_q.rw, w_q.rd, e_q.rs2)) o_fwdBE = 2'b01;
    end
  end

  // Stall/flush priority: busy > branch > load-use. Gated by reset so a
  // stray branch input cannot flush while the controller is held in reset.
  always_comb begin
    o_stallF = 1'b0;
    o_stallD = 1'b0;
    o_stallE = 1'b0;
    o_flushD = 1'b0;
    o_flushE = 1'b0;
    o_flushM = 1'b0;
    if (i_rst) begin
      if (busy) begin
        o_stallF = 1'b1;
        o_stallD = 1'b1;
        o_stallE = 1'b1;
        o_flushM = 1'b1;
      end else if (i_branchTakenE) begin
        o_flushD = 1'b1;
        o_flushE = 1'b1;
      end else if (lu) begin
        o_stallF = 1'b1;
        o_stallD = 1'b1;
        o_flushE = 1'b1;
      end
    end
  end

  // Shadow pipeline advance and multi-cycle counter.
  always_comb begin
    w_d   = m_q;
    m_d   = '0;
    e_d   = e_q;
    cnt_d = cnt_q;
    if (!busy) begin
      m_d.v  = e_q.v;
      m_d.rd = e_q.rd;
      m_d.rw = e_q.rw;
      if (o_flushE) begin
        e_d = '0;
      end else begin
        e_d.v   = i_validD;
        e_d.rd  = i_rdD;
        e_d.rw  = i_regWriteD;
        e_d.mr  = i_memReadD;
        e_d.rs1 = i_rs1D;
        e_d.rs2 = i_rs2D;
        e_d.u1  = i_useRs1D;
        e_d.u2  = i_useRs2D;
        if (i_validD && i_multiCycleD) cnt_d = CNT_LOAD;
      end
    end else begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      e_q   <= '0;
      m_q   <= '0;
      w_q   <= '0;
      cnt_q <= '0;
    end else begin
      e_q   <= e_d;
      m_q   <= m_d;
      w_q   <= w_d;
      cnt_q <= cnt_d;
    end
  end

endmodule
